rd_resp_collector: RTL and testbench
====================================

// Module: rd_resp_collector
// PURPOSE
//  Downstream consumer of the APB read-response stream (rd_valid/rd_data) of the
//  arbiter->FIFO->APB master/slave subsystem. Buffers each read beat with a sequence
//  tag in a small first-word-fall-through FIFO and offers it on a valid/ready port.
//  Keeps a beat counter, a rotate-XOR checksum and a sticky overflow flag.
//  rd_valid has no backpressure, so a beat arriving when the buffer is full is dropped.
// PARAMETERS
//  DEPTH   4   buffer entries; power of 2, >=2
//  DATA_W  32  read data width
//  SEQ_W   8   sequence tag width; wraps modulo 2^SEQ_W
//  CNT_W   16  width of beat_cnt_o and drop_cnt_o; both saturate
// PORTS
//  clk          in   1       clock; all logic on posedge
//  reset        in   1       synchronous, active-high reset
//  rd_valid_i   in   1       read beat valid; one beat per high cycle
//  rd_data_i    in   DATA_W  read beat data; sampled only when rd_valid_i=1
//  clear_i      in   1       synchronous flush of buffer, counters, checksum, flag
//  out_valid_o  out  1       buffer head valid (FWFT)
//  out_ready_i  in   1       consumer accepts head when out_valid_o & out_ready_i
//  out_data_o   out  DATA_W  head data
//  out_seq_o    out  SEQ_W   head sequence tag
//  beat_cnt_o   out  CNT_W   accepted beats since reset/clear
//  drop_cnt_o   out  CNT_W   dropped beats since reset/clear
//  checksum_o   out  DATA_W  running checksum over accepted beats
//  overflow_o   out  1       sticky; set on the first dropped beat
// BEHAVIOUR
//  - Reset: out_valid_o=0, out_data_o=0, out_seq_o=0, beat_cnt_o=0, drop_cnt_o=0,
//    checksum_o=0, overflow_o=0. Internal rd/wr pointers, count and seq_nxt all 0.
//  - Priority: reset > clear_i > normal operation.
//  - clear_i=1 has the same effect as reset on the next edge. A beat or pop in the
//    same cycle is ignored: it is not counted and not dropped.
//  - pop = out_valid_o & out_ready_i. push = rd_valid_i & (~full | pop).
//    When full, a simultaneous pop frees a slot and the beat is accepted.
//  - Accepted beat: the entry stores {seq_nxt, rd_data_i}; seq_nxt <= seq_nxt+1 (wraps);
//    beat_cnt_o +1 (saturates at all-ones);
//    checksum_o <= {checksum_o[DATA_W-2:0], checksum_o[DATA_W-1]} ^ rd_data_i.
//  - Dropped beat (rd_valid_i & full & ~pop): data is discarded; seq_nxt, beat_cnt_o
//    and checksum_o are unchanged; drop_cnt_o +1 (saturates); overflow_o <= 1 until
//    reset/clear.
//  - Latency: a beat accepted at edge N is presented at out_* after edge N when the
//    buffer was empty (1 cycle, registered storage, no comb rd->out path).
//  - out_data_o and out_seq_o are 0 whenever out_valid_o=0.
//  - Handshake: out_valid_o, once high, stays high with stable data/seq until popped.
//    out_valid_o does not depend combinationally on out_ready_i.
//  - Simultaneous push+pop on an empty buffer: pop is impossible (out_valid_o=0), so
//    only the push occurs. Push+pop otherwise leaves count unchanged.
//  - Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
//    full = (count==DEPTH); empty = (count==0).
//  - Storage order is strictly FIFO; seq tags at the output increase by 1 per pop
//    except across dropped beats, where no tag is consumed.
// TESTING
//  1 reset, then rd_valid 1 cycle with data 32'hA5A5_0001, ready=1 -> out_valid 1 cycle
//    later, data A5A5_0001, seq 0; beat_cnt=1; checksum=A5A5_0001.
//  2 ready=0, 6 back-to-back beats D0..D5 (DEPTH=4) -> D0..D3 buffered seq 0..3;
//    drop_cnt=2, overflow=1, beat_cnt=4; then ready=1 -> pops D0..D3 in order.
//  3 full buffer, beat with ready=1 in the same cycle -> head popped, beat accepted,
//    no drop, count stays 4.
//  4 beats 1,2 -> checksum = rotl(1)^2 = 32'h0000_0000; beat 3 -> 32'h0000_0003.
//  5 clear_i with rd_valid_i=1 while 2 entries are held -> next cycle out_valid=0, all
//    counters/checksum/overflow 0, beat not counted.
//  6 reset mid-burst (3 entries, ready toggling) -> all outputs return to reset values
//    the next cycle; first beat after reset gets seq 0.

Source files
------------

// File: rtl/rd_resp_collector.sv
// Read-response collector: FWFT buffer of {seq, data} beats with beat/drop counters,
// rotate-XOR checksum and sticky overflow. Incoming beats have no backpressure.
module rd_resp_collector #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int SEQ_W  = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_valid_i,
    input  logic [DATA_W-1:0] rd_data_i,
    input  logic              clear_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [SEQ_W-1:0]  out_seq_o,
    output logic [CNT_W-1:0]  beat_cnt_o,
    output logic [CNT_W-1:0]  drop_cnt_o,
    output logic [DATA_W-1:0] checksum_o,
    output logic              overflow_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    typedef struct packed {
        logic [SEQ_W-1:0]  seq;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [PTR_W:0]   count;
    logic [SEQ_W-1:0] seq_nxt;
    logic             full, empty, pop, push, drop;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign out_valid_o = ~empty;
    // A flush cycle neither consumes nor accepts anything.
    assign pop   = out_valid_o & out_ready_i & ~clear_i;
    assign push  = rd_valid_i & ~clear_i & (~full | pop);
    assign drop  = rd_valid_i & ~clear_i & full & ~pop;

    always_comb begin
        out_data_o = '0;
        out_seq_o  = '0;
        if (out_valid_o) begin
            out_data_o = mem[rd_ptr].data;
            out_seq_o  = mem[rd_ptr].seq;
        end
    end

    // Storage needs no reset: the head is masked whenever the buffer is empty.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= '{seq: seq_nxt, data: rd_data_i};
    end

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            seq_nxt    <= '0;
            beat_cnt_o <= '0;
            drop_cnt_o <= '0;
            checksum_o <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push) begin
                wr_ptr     <= wr_ptr + 1'b1;
                seq_nxt    <= seq_nxt + 1'b1;
                checksum_o <= {checksum_o[DATA_W-2:0], checksum_o[DATA_W-1]} ^ rd_data_i;
                if (beat_cnt_o != '1)
                    beat_cnt_o <= beat_cnt_o + 1'b1;
            end
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
            if (drop) begin
                overflow_o <= 1'b1;
                if (drop_cnt_o != '1)
                    drop_cnt_o <= drop_cnt_o + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_rd_resp_collector.sv
// Bench for rd_resp_collector: scoreboard of expected {seq,data} heads plus a
// reference model of counters, checksum and overflow.
module tb_rd_resp_collector;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rd_valid_i = 1'b0;
    logic [31:0] rd_data_i = '0;
    logic        clear_i = 1'b0;
    logic        out_ready_i = 1'b0;
    logic        out_valid_o;
    logic [31:0] out_data_o;
    logic [7:0]  out_seq_o;
    logic [15:0] beat_cnt_o, drop_cnt_o;
    logic [31:0] checksum_o;
    logic        overflow_o;

    rd_resp_collector #(.DEPTH(4), .DATA_W(32), .SEQ_W(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .rd_valid_i(rd_valid_i), .rd_data_i(rd_data_i),
        .clear_i(clear_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_data_o(out_data_o), .out_seq_o(out_seq_o), .beat_cnt_o(beat_cnt_o),
        .drop_cnt_o(drop_cnt_o), .checksum_o(checksum_o), .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [39:0] m_q [$];
    logic [7:0]  m_seq;
    logic [15:0] m_beat, m_drop;
    logic [31:0] m_cks;
    logic        m_ovf;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        m_seq = '0; m_beat = '0; m_drop = '0; m_cks = '0; m_ovf = 1'b0;
    endtask

    task automatic check_state();
        chk("valid", out_valid_o, m_q.size() != 0);
        chk("beat",  beat_cnt_o, m_beat);
        chk("drop",  drop_cnt_o, m_drop);
        chk("cks",   checksum_o, m_cks);
        chk("ovf",   overflow_o, m_ovf);
    endtask

    // Drive one cycle; heads are compared just before the edge that pops them.
    task automatic step(input logic v, input logic [31:0] d, input logic rdy, input logic clr);
        int  sz;
        logic pop;
        rd_valid_i = v; rd_data_i = d; out_ready_i = rdy; clear_i = clr;
        #1;
        sz = m_q.size();
        if (sz > 0) begin
            chk("head_data", out_data_o, m_q[0][31:0]);
            chk("head_seq",  out_seq_o,  m_q[0][39:32]);
        end else begin
            chk("idle_data", out_data_o, 0);
            chk("idle_seq",  out_seq_o,  0);
        end
        if (clr) begin
            model_clear();
        end else begin
            pop = rdy && (sz > 0);
            if (pop) void'(m_q.pop_front());
            if (v) begin
                if (sz < 4 || pop) begin
                    m_q.push_back({m_seq, d});
                    m_seq++;
                    if (m_beat != 16'hFFFF) m_beat++;
                    m_cks = {m_cks[30:0], m_cks[31]} ^ d;
                end else begin
                    if (m_drop != 16'hFFFF) m_drop++;
                    m_ovf = 1'b1;
                end
            end
        end
        @(posedge clk); #1;
        check_state();
    endtask

    task automatic do_reset(input logic v);
        reset = 1'b1; rd_valid_i = v; rd_data_i = 32'hDEAD_BEEF; out_ready_i = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; rd_valid_i = 1'b0;
        model_clear();
        check_state();
        chk("rst_data", out_data_o, 0);
        chk("rst_seq",  out_seq_o, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && m_q.size() > 0; i++) step(0, 0, 1, 0);
        chk("drained", out_valid_o, 0);
    endtask

    initial begin
        model_clear();
        @(posedge clk); #1;
        do_reset(0);

        // 1: single beat, one-cycle latency
        step(1, 32'hA5A5_0001, 1, 0);
        chk("t1_valid", out_valid_o, 1);
        chk("t1_data", out_data_o, 32'hA5A5_0001);
        chk("t1_seq", out_seq_o, 0);
        chk("t1_beat", beat_cnt_o, 1);
        chk("t1_cks", checksum_o, 32'hA5A5_0001);
        drain();

        // 2: overflow with ready low, then drain in order
        do_reset(0);
        for (int i = 0; i < 6; i++) step(1, 32'hD000_0000 + i, 0, 0);
        chk("t2_drop", drop_cnt_o, 2);
        chk("t2_ovf", overflow_o, 1);
        chk("t2_beat", beat_cnt_o, 4);
        chk("t2_head", out_data_o, 32'hD000_0000);
        drain();
        chk("t2_ovf_sticky", overflow_o, 1);

        // 3: full buffer, simultaneous pop + beat is accepted
        do_reset(0);
        for (int i = 0; i < 4; i++) step(1, 32'h3000_0000 + i, 0, 0);
        step(1, 32'h3000_0004, 1, 0);
        chk("t3_drop", drop_cnt_o, 0);
        chk("t3_beat", beat_cnt_o, 5);
        chk("t3_head_seq", out_seq_o, 1);
        chk("t3_count", m_q.size(), 4);
        drain();

        // 4: checksum rotate-XOR
        do_reset(0);
        step(1, 32'h1, 1, 0);
        step(1, 32'h2, 1, 0);
        chk("t4_cks12", checksum_o, 32'h0);
        step(1, 32'h3, 1, 0);
        chk("t4_cks123", checksum_o, 32'h3);
        drain();

        // 5: clear with a beat in flight while 2 entries held
        do_reset(0);
        step(1, 32'h5000_0000, 0, 0);
        step(1, 32'h5000_0001, 0, 0);
        step(1, 32'h5000_0002, 1, 1);
        chk("t5_valid", out_valid_o, 0);
        chk("t5_beat", beat_cnt_o, 0);
        chk("t5_cks", checksum_o, 0);
        step(1, 32'h5000_0003, 0, 0);
        chk("t5_seq0", out_seq_o, 0);
        drain();

        // 6: reset mid-burst with ready toggling
        do_reset(0);
        for (int i = 0; i < 5; i++) step(1, 32'h6000_0000 + i, i[0], 0);
        do_reset(1);
        step(1, 32'h6000_00AA, 0, 0);
        chk("t6_seq0", out_seq_o, 0);
        chk("t6_data", out_data_o, 32'h6000_00AA);
        drain();

        // Random traffic against the model
        do_reset(0);
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 60) == 0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
